// File: rtl/ram_bank_scheduler_if.sv
// ram_bank_scheduler_if: loader, evolution, manual and VGA ports plus the four-RAM bus of the bank scheduler.
interface ram_bank_scheduler_if #(parameter int ADDR_W = 24);
    logic              ld_busy, ld_wr_en, ld_wr_val;
    logic [ADDR_W-1:0] ld_addr;
    logic              running, evo_tick, manual_active;
    logic [ADDR_W-1:0] man_addr;
    logic              man_wr_en, man_wr_val, man_rd_val;
    logic              round_go, round_abort;
    logic [ADDR_W-1:0] round_rd_addr, round_wr_addr;
    logic              round_wr_en, round_wr_val, round_done, round_rd_val;
    logic [ADDR_W-1:0] vga_addr;
    logic              vga_val;
    logic [ADDR_W-1:0] ram_addr [4];
    logic              ram_wren [4];
    logic              ram_rden [4];
    logic              ram_wdata [4];
    logic              ram_q [4];
    logic              front, overrun;
    logic [2:0]        state_o;

    modport slave (
        input  ld_busy, ld_addr, ld_wr_en, ld_wr_val, running, evo_tick, manual_active,
               man_addr, man_wr_en, man_wr_val, round_rd_addr, round_wr_addr,
               round_wr_en, round_wr_val, round_done, vga_addr, ram_q,
        output man_rd_val, round_go, round_abort, round_rd_val, vga_val,
               ram_addr, ram_wren, ram_rden, ram_wdata, front, state_o, overrun
    );

    modport master (
        output ld_busy, ld_addr, ld_wr_en, ld_wr_val, running, evo_tick, manual_active,
               man_addr, man_wr_en, man_wr_val, round_rd_addr, round_wr_addr,
               round_wr_en, round_wr_val, round_done, vga_addr, ram_q,
        input  man_rd_val, round_go, round_abort, round_rd_val, vga_val,
               ram_addr, ram_wren, ram_rden, ram_wdata, front, state_o, overrun
    );
endinterface

// File: rtl/ram_bank_scheduler.sv
// ram_bank_scheduler: routes loader, evolution, manual and VGA traffic onto two ping-pong RAM pairs
// (RAM 2p evaluation copy, RAM 2p+1 display copy of pair p).
module ram_bank_scheduler #(
    parameter int ADDR_W = 24,
    parameter int CELLS  = 480000
) (
    input logic clk,
    input logic rst,
    ram_bank_scheduler_if.slave bus
);
    typedef enum logic [2:0] {IDLE = 3'd0, LOAD = 3'd1, EVOLVE = 3'd2, SWAP = 3'd3, EDIT = 3'd4} state_e;

    if (CELLS > 2 ** ADDR_W) begin : g_cells_chk
        $error("CELLS does not fit in ADDR_W address bits");
    end

    state_e            state_q, state_d, dly_state_q;
    logic              front_q, overrun_q, go_q, abort_q, vga_hold_q;
    logic              dly_vld_q, dly_front_q, dly_men_q;
    logic              man_wr;
    logic [ADDR_W-1:0] addr_d [4];

    assign man_wr = state_q == EDIT && bus.man_wr_en;

    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE:    state_d = bus.ld_busy ? LOAD : bus.manual_active ? EDIT :
                               (bus.evo_tick && bus.running) ? EVOLVE : IDLE;
            LOAD:    state_d = bus.ld_busy ? LOAD : IDLE;
            EVOLVE:  state_d = bus.ld_busy ? LOAD : bus.round_done ? SWAP : EVOLVE;
            SWAP:    state_d = IDLE;
            EDIT:    state_d = bus.ld_busy ? LOAD : bus.manual_active ? EDIT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            addr_d[i]        = '0;
            bus.ram_wren[i]  = 1'b0;
            bus.ram_rden[i]  = 1'b0;
            bus.ram_wdata[i] = 1'b0;
            if (state_q == LOAD || man_wr) begin
                addr_d[i]        = state_q == LOAD ? bus.ld_addr : bus.man_addr;
                bus.ram_wren[i]  = state_q == LOAD ? bus.ld_wr_en : 1'b1;
                bus.ram_wdata[i] = state_q == LOAD ? bus.ld_wr_val : bus.man_wr_val;
            end else if (i[1] != front_q) begin
                addr_d[i]        = state_q == EVOLVE ? bus.round_wr_addr : '0;
                bus.ram_wren[i]  = state_q == EVOLVE && bus.round_wr_en;
                bus.ram_wdata[i] = state_q == EVOLVE && bus.round_wr_val;
            end else begin
                addr_d[i]        = i[0] ? bus.vga_addr : state_q == EVOLVE ? bus.round_rd_addr : bus.man_addr;
                bus.ram_rden[i]  = 1'b1;
            end
        end
    end

    assign bus.ram_addr = addr_d;

    // Read data follows the routing of the cycle that issued the address, not the current one.
    assign bus.round_rd_val = dly_vld_q && bus.ram_q[{dly_front_q, 1'b0}];
    assign bus.man_rd_val   = dly_vld_q && bus.ram_q[{dly_front_q, 1'b0}];
    assign bus.vga_val      = (!dly_vld_q || state_q == LOAD || dly_state_q == LOAD) ? 1'b0 :
                              (dly_state_q == EDIT && dly_men_q) ? vga_hold_q : bus.ram_q[{dly_front_q, 1'b1}];

    assign bus.round_go    = go_q;
    assign bus.round_abort = abort_q;
    assign bus.front       = front_q;
    assign bus.overrun     = overrun_q;
    assign bus.state_o     = state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            front_q     <= 1'b0;
            overrun_q   <= 1'b0;
            go_q        <= 1'b0;
            abort_q     <= 1'b0;
            vga_hold_q  <= 1'b0;
            dly_vld_q   <= 1'b0;
            dly_state_q <= IDLE;
            dly_front_q <= 1'b0;
            dly_men_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            front_q     <= front_q ^ (state_q == SWAP);
            overrun_q   <= overrun_q | (bus.evo_tick && bus.running && state_q != IDLE);
            go_q        <= state_q == IDLE && state_d == EVOLVE;
            abort_q     <= state_q == EVOLVE && bus.ld_busy;
            vga_hold_q  <= bus.vga_val;
            dly_vld_q   <= 1'b1;
            dly_state_q <= state_q;
            dly_front_q <= front_q;
            dly_men_q   <= bus.man_wr_en;
        end
    end
endmodule

// File: tb/tb_ram_bank_scheduler.sv
// tb_ram_bank_scheduler: directed scenarios plus randomized traffic checked against a cell-level model
// of the four RAMs and the scheduler's mode rules.
module tb_ram_bank_scheduler;
    localparam int AW = 24;
    localparam int N  = 256;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clr = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    ram_bank_scheduler_if #(.ADDR_W(AW)) bus ();
    ram_bank_scheduler #(.ADDR_W(AW), .CELLS(480000)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // RAM behaviour: 1-cycle read; q toggles when not read so stale data is never mistaken for a hold
    logic mem [4][N];
    always @(posedge clk)
        for (int i = 0; i < 4; i++) begin
            if (clr) for (int j = 0; j < N; j++) mem[i][j] <= 1'b0;
            else if (bus.ram_wren[i]) mem[i][bus.ram_addr[i][7:0]] <= bus.ram_wdata[i];
            bus.ram_q[i] <= bus.ram_rden[i] ? mem[i][bus.ram_addr[i][7:0]] : ~bus.ram_q[i];
        end

    int m_state;
    bit m_front, m_over, m_go, m_abort, exp_vga, exp_rd, rd_known;
    bit sh [4][N];

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_front = 0; m_over = 0; m_go = 0; m_abort = 0;
        exp_vga = 0; exp_rd = 0; rd_known = 1;
    endtask

    task automatic model_edge();
        int s = m_state;
        int f = int'(m_front);
        bit wr = s == 4 && bus.man_wr_en;
        if (s == 1) begin
            exp_vga = 0; rd_known = 0;
        end else if (wr) rd_known = 0;
        else begin
            exp_vga  = sh[2*f+1][bus.vga_addr[7:0]];
            exp_rd   = sh[2*f][s == 2 ? bus.round_rd_addr[7:0] : bus.man_addr[7:0]];
            rd_known = 1;
        end
        if (s == 1 && bus.ld_wr_en) for (int i = 0; i < 4; i++) sh[i][bus.ld_addr[7:0]] = bus.ld_wr_val;
        if (s == 2 && bus.round_wr_en) begin
            sh[2-2*f][bus.round_wr_addr[7:0]] = bus.round_wr_val;
            sh[3-2*f][bus.round_wr_addr[7:0]] = bus.round_wr_val;
        end
        if (wr) for (int i = 0; i < 4; i++) sh[i][bus.man_addr[7:0]] = bus.man_wr_val;
        m_over  = m_over | (bus.evo_tick && bus.running && s != 0);
        m_go    = s == 0 && !bus.ld_busy && !bus.manual_active && bus.evo_tick && bus.running;
        m_abort = s == 2 && bus.ld_busy;
        if (s == 3) m_front = !m_front;
        case (s)
            0:       m_state = bus.ld_busy ? 1 : bus.manual_active ? 4 : m_go ? 2 : 0;
            1:       m_state = bus.ld_busy ? 1 : 0;
            2:       m_state = bus.ld_busy ? 1 : bus.round_done ? 3 : 2;
            3:       m_state = 0;
            default: m_state = bus.ld_busy ? 1 : bus.manual_active ? 4 : 0;
        endcase
    endtask

    task automatic check_all();
        chk("state", 32'(bus.state_o), m_state);
        chk("front", 32'(bus.front), 32'(m_front));
        chk("overrun", 32'(bus.overrun), 32'(m_over));
        chk("round_go", 32'(bus.round_go), 32'(m_go));
        chk("round_abort", 32'(bus.round_abort), 32'(m_abort));
        chk("vga_val", 32'(bus.vga_val), m_state == 1 ? 0 : 32'(exp_vga));
        if (rd_known) begin
            chk("man_rd_val", 32'(bus.man_rd_val), 32'(exp_rd));
            chk("round_rd_val", 32'(bus.round_rd_val), 32'(exp_rd));
        end
        if (m_state == 0 || m_state == 3)
            chk("wren_idle", {bus.ram_wren[3], bus.ram_wren[2], bus.ram_wren[1], bus.ram_wren[0]}, 0);
    endtask

    task automatic step();
        #1 check_all();
        @(posedge clk);
        #1 model_edge();
    endtask

    task automatic evo_cycles(int n);
        for (int k = 0; k < n; k++) begin
            bus.round_wr_en   = 1'($urandom);
            bus.round_wr_addr = AW'($urandom_range(10, 99));
            bus.round_wr_val  = 1'($urandom);
            bus.round_rd_addr = AW'($urandom_range(0, N-1));
            bus.vga_addr      = AW'($urandom_range(0, N-1));
            step();
        end
        bus.round_wr_en = 1'b0;
    endtask

    initial begin
        bit v, r0, v_prev;
        int bad;
        bus.ld_busy = 0; bus.ld_addr = '0; bus.ld_wr_en = 0; bus.ld_wr_val = 0;
        bus.running = 0; bus.evo_tick = 0; bus.manual_active = 0;
        bus.man_addr = '0; bus.man_wr_en = 0; bus.man_wr_val = 0;
        bus.round_rd_addr = '0; bus.round_wr_addr = '0; bus.round_wr_en = 0;
        bus.round_wr_val = 0; bus.round_done = 0; bus.vga_addr = '0;
        for (int i = 0; i < 4; i++) for (int j = 0; j < N; j++) sh[i][j] = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 0; clr = 0;
        step();

        // Load every cell; addr 5 gets 1 in all four RAMs
        bus.ld_busy = 1;
        step();
        for (int a = 0; a < N; a++) begin
            bus.ld_addr = AW'(a); bus.ld_wr_en = 1; bus.ld_wr_val = a == 5 ? 1'b1 : 1'($urandom);
            bus.vga_addr = AW'($urandom_range(0, N-1));
            step();
        end
        bus.ld_wr_en = 0; bus.ld_busy = 0;
        step();
        chk("load_idle", 32'(bus.state_o), 0);
        for (int i = 0; i < 4; i++) chk("load_a5", 32'(mem[i][5]), 1);

        // Generation with front=0: writes go to RAM2/3 only
        bus.running = 1; bus.evo_tick = 1;
        step();
        bus.evo_tick = 0;
        chk("gen_go", 32'(bus.round_go), 1);
        chk("gen_state", 32'(bus.state_o), 2);
        v = !sh[2][7]; r0 = sh[0][7];
        bus.round_wr_en = 1; bus.round_wr_addr = AW'(7); bus.round_wr_val = v;
        step();
        bus.round_wr_en = 0;
        chk("gen_go_once", 32'(bus.round_go), 0);
        chk("gen_wr2", 32'(mem[2][7]), 32'(v));
        chk("gen_wr3", 32'(mem[3][7]), 32'(v));
        chk("gen_keep0", 32'(mem[0][7]), 32'(r0));
        chk("gen_keep1", 32'(mem[1][7]), 32'(r0));
        evo_cycles(3);
        bus.evo_tick = 1;
        step();
        bus.evo_tick = 0;
        chk("ovr_set", 32'(bus.overrun), 1);
        chk("ovr_no_go", 32'(bus.round_go), 0);
        bus.round_done = 1;
        step();
        bus.round_done = 0;
        chk("swap_state", 32'(bus.state_o), 3);
        chk("swap_front", 32'(bus.front), 0);
        step();
        chk("swap_idle", 32'(bus.state_o), 0);
        chk("swap_front1", 32'(bus.front), 1);

        // Abort mid-generation
        bus.evo_tick = 1;
        step();
        bus.evo_tick = 0;
        evo_cycles(3);
        bus.ld_busy = 1;
        step();
        bus.ld_busy = 0;
        chk("abort_pulse", 32'(bus.round_abort), 1);
        chk("abort_load", 32'(bus.state_o), 1);
        chk("abort_front", 32'(bus.front), 1);
        chk("abort_ovr", 32'(bus.overrun), 1);
        step();
        step();

        // Manual edit with front=1
        bus.manual_active = 1; bus.vga_addr = AW'(5); bus.man_addr = AW'(100);
        step();
        step();
        bus.man_wr_en = 1; bus.man_wr_val = 1;
        #1 v_prev = bus.vga_val;
        step();
        bus.man_wr_en = 0;
        for (int i = 0; i < 4; i++) chk("edit_wr", 32'(mem[i][100]), 1);
        #1 chk("edit_vga_hold", 32'(bus.vga_val), 32'(v_prev));
        step();
        chk("edit_rd", 32'(bus.man_rd_val), 1);
        bus.manual_active = 0;
        step();
        step();

        // Generation swapping front back to 0, then reset during the next SWAP
        bus.evo_tick = 1;
        step();
        bus.evo_tick = 0;
        evo_cycles(4);
        bus.round_done = 1;
        step();
        bus.round_done = 0;
        step();
        chk("gen2_front", 32'(bus.front), 0);
        bus.evo_tick = 1;
        step();
        bus.evo_tick = 0;
        evo_cycles(2);
        bus.round_done = 1;
        step();
        bus.round_done = 0;
        chk("rst_in_swap", 32'(bus.state_o), 3);
        #2 rst = 1;
        #1 chk("arst_state", 32'(bus.state_o), 0);
        chk("arst_front", 32'(bus.front), 0);
        chk("arst_ovr", 32'(bus.overrun), 0);
        chk("arst_go", 32'(bus.round_go), 0);
        model_reset();
        @(posedge clk);
        #1 chk("arst_hold", 32'(bus.state_o), 0);
        rst = 0;
        step();

        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            bus.ld_busy       = $urandom_range(0, 24) == 0;
            bus.ld_addr       = AW'($urandom_range(0, N-1));
            bus.ld_wr_en      = 1'($urandom);
            bus.ld_wr_val     = 1'($urandom);
            if ($urandom_range(0, 19) == 0) bus.manual_active = !bus.manual_active;
            bus.running       = $urandom_range(0, 7) != 0;
            bus.evo_tick      = $urandom_range(0, 9) == 0;
            bus.round_done    = $urandom_range(0, 7) == 0;
            bus.man_addr      = AW'($urandom_range(0, N-1));
            bus.man_wr_en     = $urandom_range(0, 3) == 0;
            bus.man_wr_val    = 1'($urandom);
            bus.round_rd_addr = AW'($urandom_range(0, N-1));
            bus.round_wr_addr = AW'($urandom_range(0, N-1));
            bus.round_wr_en   = 1'($urandom);
            bus.round_wr_val  = 1'($urandom);
            bus.vga_addr      = AW'($urandom_range(0, N-1));
            step();
        end

        for (int i = 0; i < 4; i++) begin
            bad = 0;
            for (int j = 0; j < N; j++) if (mem[i][j] !== sh[i][j]) bad++;
            chk("mem_final", 32'(bad), 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
